pipe_stage_reg: RTL



---
 rtl/pipe_stage_reg.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Pipeline-stage register carrying one WIDTH-bit stage bundle between two
//   processor pipeline stages, with valid/ready handshake, back-pressure,
//   synchronous flush and a programmable reset value.
//
//   Build option: define PIPE_STAGE_SKID_EN to get a two-entry skid buffer
//   (main + skid register) with a registered in_ready. Without it the stage
//   holds a single entry and in_ready is combinational.
//
// Parameters
//   WIDTH        bit width of the carried bundle (>=1)
//   RESET_VALUE  value loaded into out_data (and skid data) on reset
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high reset
//   flush      in   synchronous squash of all held entries
//   in_valid   in   upstream presents in_data
//   in_ready   out  stage accepts in_data this cycle
//   in_data    in   bundle from upstream
//   out_valid  out  out_data holds a live entry
//   out_ready  in   downstream accepts out_data this cycle (low = stall)
//   out_data   out  bundle to downstream (always a register output)
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int                WIDTH       = 16,
  parameter logic [WIDTH-1:0]  RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             accept;
  logic             out_xfer;

  assign accept   = in_valid && in_ready;
  assign out_xfer = out_valid_q && out_ready;

`ifdef PIPE_STAGE_SKID_EN

  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             in_ready_q, in_ready_d;

  // in_ready comes from a flop so out_ready never reaches it combinationally;
  // flush still gates it so nothing is taken in the squash cycle.
  assign in_ready = in_ready_q && !flush;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      // Data registers keep their contents; only the valids are cleared.
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // Skid full means in_ready was low, so no accept can coincide here.
      if (out_xfer) begin
        out_data_d   = skid_data_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q || out_xfer) begin
        out_data_d  = in_data;
        out_valid_d = 1'b1;
      end else begin
        skid_data_d  = in_data;
        skid_valid_d = 1'b1;
      end
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= RESET_VALUE;
      in_ready_q   <= 1'b1;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

`else

  // Single entry: room exists if empty or the held word leaves this edge.
  assign in_ready = (!out_valid_q || out_ready) && !flush;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_data_d  = in_data;
      out_valid_d = 1'b1;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= RESET_VALUE;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
